// File: rtl/store_lane_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : store_lane_writer_pkg
//  Purpose  : Shared encodings for the store lane writer. The load extender
//             and control decode use the same size and state encodings.
//  Contents : SZ_* size encodings, S_* writer states and the bus widths.
//  Revision : 1.0  initial release
// ============================================================================
package store_lane_writer_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  // Access size carried on ST_SIZE.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  // Writer FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ERR   = 2'd2
  } state_t;

endpackage : store_lane_writer_pkg
`default_nettype wire

// File: rtl/store_lane_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : store_lane_writer_if
//  Purpose  : Bundles the MEM-stage store handshake and the data-memory write
//             port of the store lane writer.
//  Modports : master - MEM stage / memory side (drives requests and MEM_ACK)
//             slave  - store lane writer (drives ready, write port, pulses)
//  Revision : 1.0  initial release
// ============================================================================
interface store_lane_writer_if;
  import store_lane_writer_pkg::*;

  logic              ST_VALID;
  logic              ST_READY;
  logic [ADDR_W-1:0] ST_ADDR;
  logic [1:0]        ST_SIZE;
  logic [DATA_W-1:0] ST_DATA;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [BE_W-1:0]   MEM_BE;
  logic              MEM_ACK;
  logic              MISALIGN;
  logic              BUS_ERR;

  modport master (
    output ST_VALID, ST_ADDR, ST_SIZE, ST_DATA, MEM_ACK,
    input  ST_READY, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE, MISALIGN, BUS_ERR
  );

  modport slave (
    input  ST_VALID, ST_ADDR, ST_SIZE, ST_DATA, MEM_ACK,
    output ST_READY, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE, MISALIGN, BUS_ERR
  );

endinterface : store_lane_writer_if
`default_nettype wire

// File: rtl/store_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : store_lane_align
//  Purpose  : Combinational lane mapper. Replicates the significant low bits
//             of the register value across the word and selects the byte
//             lanes addressed by the low address bits (little-endian).
//  Ports    : size_i     access size (SZ_* encoding)
//             addr_lo_i  byte offset within the word
//             data_i     register value
//             wdata_o    lane-aligned write data
//             be_o       byte enables, bit i covers wdata_o[8i+7:8i]
//             misalign_o request must be rejected (misaligned or illegal)
//  Revision : 1.0  initial release
// ============================================================================
module store_lane_align
  import store_lane_writer_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [BE_W-1:0]   be_o,
  output logic              misalign_o
);

  always_comb begin
    wdata_o    = data_i;
    be_o       = '0;
    misalign_o = 1'b0;
    unique case (size_t'(size_i))
      SZ_BYTE: begin
        wdata_o = {4{data_i[7:0]}};
        be_o    = 4'b0001 << addr_lo_i;
      end
      SZ_HALF: begin
        wdata_o    = {2{data_i[15:0]}};
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_lo_i[0];
      end
      SZ_WORD: begin
        be_o       = 4'b1111;
        misalign_o = |addr_lo_i;
      end
      SZ_ILL: begin
        misalign_o = 1'b1;
      end
    endcase
  end

endmodule : store_lane_align
`default_nettype wire

// File: rtl/store_lane_writer.sv
`default_nettype none
// ============================================================================
//  Module   : store_lane_writer
//  Purpose  : Accepts one store per handshake, aligns it into byte lanes and
//             holds a data-memory write until MEM_ACK or a timeout.
//  Ports    : CLK, RST   clock and synchronous active-high reset
//             bus        store_lane_writer_if.slave:
//                          ST_VALID/ST_READY/ST_ADDR/ST_SIZE/ST_DATA  request
//                          MEM_WE/MEM_ADDR/MEM_WDATA/MEM_BE/MEM_ACK   memory
//                          MISALIGN, BUS_ERR                          pulses
//  Params   : ACK_TIMEOUT  WRITE cycles allowed before aborting (>= 1)
//             CNT_W        timeout counter width, 2**CNT_W > ACK_TIMEOUT
//  Revision : 1.0  initial release
// ============================================================================
module store_lane_writer
  import store_lane_writer_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  store_lane_writer_if.slave   bus
);

  // Counter value seen in the last permitted WRITE cycle.
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(ACK_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;

  logic [DATA_W-1:0] al_wdata;
  logic [BE_W-1:0]   al_be;
  logic              al_mis;
  logic              accept;

  store_lane_align u_align (
    .size_i     (bus.ST_SIZE),
    .addr_lo_i  (bus.ST_ADDR[1:0]),
    .data_i     (bus.ST_DATA),
    .wdata_o    (al_wdata),
    .be_o       (al_be),
    .misalign_o (al_mis)
  );

  // ready_q is only ever set while idle, so it alone qualifies the handshake.
  assign accept = bus.ST_VALID & ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = 1'b0;
    mis_d   = 1'b0;
    berr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = {bus.ST_ADDR[ADDR_W-1:2], 2'b00};
          wdata_d = al_wdata;
          cnt_d   = '0;
          if (al_mis) begin
            // Rejected: no write, BE stays clear.
            state_d = S_ERR;
            be_d    = '0;
            mis_d   = 1'b1;
          end else begin
            state_d = S_WRITE;
            be_d    = al_be;
            we_d    = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (bus.MEM_ACK) begin
          // An ACK in the final permitted cycle still counts as success.
          state_d = S_IDLE;
          be_d    = '0;
        end else if (cnt_q == c_cnt_last) begin
          state_d = S_IDLE;
          be_d    = '0;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          we_d  = 1'b1;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        be_d    = '0;
      end
    endcase
  end

  // Ready only after a full idle cycle, so completion and rejection each
  // leave one idle, not-ready cycle before the next accept.
  always_comb begin
    ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign bus.ST_READY  = ready_q;
  assign bus.MEM_WE    = we_q;
  assign bus.MEM_ADDR  = addr_q;
  assign bus.MEM_WDATA = wdata_q;
  assign bus.MEM_BE    = be_q;
  assign bus.MISALIGN  = mis_q;
  assign bus.BUS_ERR   = berr_q;

endmodule : store_lane_writer
`default_nettype wire

// File: tb/tb_store_lane_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_lane_writer
//  Purpose  : Self-checking bench for store_lane_writer: directed scenarios
//             followed by random stores, checked against a size/offset
//             arithmetic model of the lane rules and the handshake timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_store_lane_writer;

  localparam int T = 15;
  localparam int W = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  store_lane_writer_if bus ();

  store_lane_writer #(.ACK_TIMEOUT(T), .CNT_W(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: access width in bytes and offset within the word decide
  // everything; data is replicated by multiplying by a lane-repeat constant.
  function automatic void model(input logic [31:0] a, input logic [1:0] sz,
                                input logic [31:0] d, output bit mis,
                                output logic [31:0] wd, output logic [3:0] be,
                                output logic [31:0] wa);
    int nb;
    int off;
    nb  = (sz == 2'd3) ? 0 : (1 << sz);
    off = int'(a % 32'd4);
    wa  = a - 32'(off);
    if (nb == 0) mis = 1'b1;
    else         mis = (off % nb) != 0;
    case (nb)
      1:       wd = 32'(d[7:0])  * 32'h0101_0101;
      2:       wd = 32'(d[15:0]) * 32'h0001_0001;
      default: wd = d;
    endcase
    be = (nb == 0) ? 4'b0000 : 4'(((1 << nb) - 1) << off);
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ready"},  32'(bus.ST_READY),  32'd0);
    chk({tag, "_we"},     32'(bus.MEM_WE),    32'd0);
    chk({tag, "_addr"},   bus.MEM_ADDR,       32'd0);
    chk({tag, "_wdata"},  bus.MEM_WDATA,      32'd0);
    chk({tag, "_be"},     32'(bus.MEM_BE),    32'd0);
    chk({tag, "_mis"},    32'(bus.MISALIGN),  32'd0);
    chk({tag, "_berr"},   32'(bus.BUS_ERR),   32'd0);
  endtask

  // ack_at: WRITE cycle (1-based) in which MEM_ACK is raised; 0 = never.
  task automatic do_store(input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] d, input int ack_at);
    bit          mis;
    bit          timed_out;
    logic [31:0] wd;
    logic [31:0] wa;
    logic [3:0]  be;
    model(a, sz, d, mis, wd, be, wa);
    chk("ready_before", 32'(bus.ST_READY), 32'd1);
    bus.ST_VALID = 1'b1;
    bus.ST_ADDR  = a;
    bus.ST_SIZE  = sz;
    bus.ST_DATA  = d;
    bus.MEM_ACK  = 1'($urandom_range(0, 1));
    @(negedge CLK);
    // Inputs change after the accept edge; the write in flight must not care.
    bus.ST_VALID = 1'b0;
    bus.ST_ADDR  = $urandom;
    bus.ST_SIZE  = 2'($urandom);
    bus.ST_DATA  = $urandom;
    bus.MEM_ACK  = 1'($urandom_range(0, 1));
    if (mis) begin
      chk("err_misalign", 32'(bus.MISALIGN), 32'd1);
      chk("err_we",       32'(bus.MEM_WE),   32'd0);
      chk("err_be",       32'(bus.MEM_BE),   32'd0);
      chk("err_ready",    32'(bus.ST_READY), 32'd0);
      @(negedge CLK);
      chk("err_pulse_end", 32'(bus.MISALIGN), 32'd0);
      chk("err_we2",       32'(bus.MEM_WE),   32'd0);
      chk("err_ready2",    32'(bus.ST_READY), 32'd0);
      @(negedge CLK);
      chk("err_ready_back", 32'(bus.ST_READY), 32'd1);
      chk("err_we3",        32'(bus.MEM_WE),   32'd0);
    end else begin
      timed_out = 1'b1;
      for (int k = 1; k <= T; k++) begin
        chk("wr_we",    32'(bus.MEM_WE),   32'd1);
        chk("wr_addr",  bus.MEM_ADDR,      wa);
        chk("wr_wdata", bus.MEM_WDATA,     wd);
        chk("wr_be",    32'(bus.MEM_BE),   32'(be));
        chk("wr_ready", 32'(bus.ST_READY), 32'd0);
        chk("wr_berr",  32'(bus.BUS_ERR),  32'd0);
        chk("wr_mis",   32'(bus.MISALIGN), 32'd0);
        bus.MEM_ACK = (k == ack_at);
        @(negedge CLK);
        if (k == ack_at) begin
          timed_out = 1'b0;
          break;
        end
      end
      // MEM_ACK while not writing must be ignored.
      bus.MEM_ACK = 1'($urandom_range(0, 1));
      chk("done_we",    32'(bus.MEM_WE),   32'd0);
      chk("done_be",    32'(bus.MEM_BE),   32'd0);
      chk("done_berr",  32'(bus.BUS_ERR),  32'(timed_out));
      chk("done_ready", 32'(bus.ST_READY), 32'd0);
      @(negedge CLK);
      bus.MEM_ACK = 1'b0;
      chk("berr_end",   32'(bus.BUS_ERR),  32'd0);
      chk("ready_back", 32'(bus.ST_READY), 32'd1);
      chk("idle_we",    32'(bus.MEM_WE),   32'd0);
    end
  endtask

  initial begin
    bus.ST_VALID = 1'b0;
    bus.ST_ADDR  = '0;
    bus.ST_SIZE  = '0;
    bus.ST_DATA  = '0;
    bus.MEM_ACK  = 1'b0;

    // Reset: outputs stay zero even with a request presented.
    @(negedge CLK);
    chk_idle_zero("rst0");
    bus.ST_VALID = 1'b1;
    bus.ST_ADDR  = 32'h0000_1000;
    bus.ST_SIZE  = 2'b10;
    bus.ST_DATA  = 32'hDEAD_BEEF;
    repeat (2) begin
      @(negedge CLK);
      chk_idle_zero("rst");
    end
    bus.ST_VALID = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    chk("rel_ready", 32'(bus.ST_READY), 32'd1);
    chk("rel_we",    32'(bus.MEM_WE),   32'd0);
    @(negedge CLK);
    chk("rel_ready2", 32'(bus.ST_READY), 32'd1);
    chk("rel_we2",    32'(bus.MEM_WE),   32'd0);

    // Directed scenarios.
    do_store(32'h0000_1003, 2'b00, 32'h0000_00AB, 1);
    do_store(32'h0000_2002, 2'b01, 32'h1234_BEEF, 6);
    do_store(32'h0000_3001, 2'b10, $urandom, 1);
    do_store(32'h0000_3000, 2'b11, $urandom, 1);
    do_store(32'h0000_4000, 2'b10, $urandom, 0);
    do_store(32'h0000_4000, 2'b10, $urandom, T);
    do_store(32'h0000_5001, 2'b00, 32'hFFFF_FF5A, 2);
    do_store(32'h0000_5000, 2'b01, 32'hCAFE_0123, 1);

    // Reset in the third WRITE cycle.
    chk("mid_ready", 32'(bus.ST_READY), 32'd1);
    bus.ST_VALID = 1'b1;
    bus.ST_ADDR  = 32'h0000_6000;
    bus.ST_SIZE  = 2'b10;
    bus.ST_DATA  = 32'h0BAD_F00D;
    @(negedge CLK);
    bus.ST_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_we3", 32'(bus.MEM_WE), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_we",    32'(bus.MEM_WE),   32'd0);
    chk("mid_rst_be",    32'(bus.MEM_BE),   32'd0);
    chk("mid_rst_berr",  32'(bus.BUS_ERR),  32'd0);
    chk("mid_rst_mis",   32'(bus.MISALIGN), 32'd0);
    chk("mid_rst_ready", 32'(bus.ST_READY), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_rel_ready", 32'(bus.ST_READY), 32'd1);
    chk("mid_rel_berr",  32'(bus.BUS_ERR),  32'd0);
    chk("mid_rel_mis",   32'(bus.MISALIGN), 32'd0);
    do_store(32'h0000_7004, 2'b10, $urandom, 2);

    // Random stores.
    for (int i = 0; i < 40; i++) begin
      do_store($urandom, 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, T));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_store_lane_writer
`default_nettype wire
